user_proj_counter_bank: RTL and testbench
=========================================

// Module: user_proj_counter_bank
// PURPOSE
//  Parametrised multi-channel counter/timer user project for the Caravel user area, instantiated as mprj by user_project_wrapper.
//  NUM_CH independent CNT_W-bit counters, each up/down with optional auto-reload.
//  Control is over a Wishbone slave. Channel 0 can be observed and overridden through the logic analyser.
//  One selectable channel drives the user IOs; terminal-count events raise user_irq[0].
// PARAMETERS
//  NUM_CH    4             number of counter channels, 1..16
//  CNT_W     32            counter width in bits, 1..32; reads zero-extend to 32
//  BASE_ADR  32'h3000_0000 Wishbone window base; window = BASE_ADR + [0x000..0x0FF]
//  IO_CH     0             channel whose count drives io_out, < NUM_CH
// PORTS
//  wb_clk_i     in   1    clock
//  wb_rst_i     in   1    synchronous, active-high reset
//  wbs_cyc_i    in   1    Wishbone cycle
//  wbs_stb_i    in   1    Wishbone strobe
//  wbs_we_i     in   1    Wishbone write enable
//  wbs_sel_i    in   4    byte selects
//  wbs_adr_i    in   32   byte address
//  wbs_dat_i    in   32   write data
//  wbs_ack_o    out  1    acknowledge
//  wbs_dat_o    out  32   read data
//  la_data_in   in   128  LA data; [CNT_W-1:0] = channel-0 override value
//  la_data_out  out  128  [31:0] ch0 count, [63:32] ch1, [95:64] ch2, [127:96] tc flags
//  la_oenb      in   128  bit 64 low = LA override of channel 0 active
//  io_in        in   38   unused
//  io_out       out  38   [37:6] = count of IO_CH (zero-extended); [5:0] = 0
//  io_oeb       out  38   [37:6] = 0 (drive), [5:0] = 1 (input)
//  irq          out  3    [0] = counter interrupt; [2:1] tied 0
// BEHAVIOUR
//  Reset: all CTRL/COUNT/RELOAD/STATUS = 0; wbs_ack_o = 0; wbs_dat_o = 0; irq = 0; la_data_out = 0.
//  Register map: channel c at BASE_ADR + c*0x10.
//    +0x0 CTRL: b0 EN, b1 AUTO (auto-reload), b2 IE (irq enable), b3 DOWN
//    +0x4 COUNT
//    +0x8 RELOAD
//    +0xC STATUS: b0 TC sticky, write-1-to-clear
//  Reads of unmapped offsets or c >= NUM_CH return 0. Writes to them are ignored but still acked.
//  Wishbone:
//    - stb&cyc&!ack samples the request; wbs_ack_o is high exactly the next cycle, for one cycle.
//    - Read data is valid with ack.
//    - Back-to-back requests are acked every other cycle.
//    - Addresses outside the window are never acked.
//    - Writes honour wbs_sel_i per byte; bits >= CNT_W are dropped.
//  Counting, per channel, each cycle EN=1:
//    - Up (DOWN=0): when COUNT==RELOAD, terminal; else COUNT+1.
//    - Down (DOWN=1): when COUNT==0, terminal; else COUNT-1.
//    - Terminal cycle, up: sets TC; COUNT <= 0 if AUTO, else EN <= 0 and COUNT holds.
//    - Terminal cycle, down: sets TC; COUNT <= RELOAD if AUTO, else EN <= 0 and COUNT holds.
//    - EN=0: COUNT holds.
//  COUNT update priority, highest first:
//    - LA override (ch0 only, ~la_oenb[64]): COUNT0 <= la_data_in[CNT_W-1:0]; no TC for ch0 that cycle.
//    - Wishbone COUNT write.
//    - Counting.
//  TC set by a terminal event wins over a simultaneous W1C in the same cycle.
//  A CTRL write clearing EN on the same cycle as auto-disable gives EN=0 (no conflict).
//  irq[0] is registered: irq[0] <= |(TC & IE) over all channels; one cycle latency; 0 when NUM_CH channels are idle/clear.
//  la_data_out and io_out are registered copies of COUNT/TC; one cycle behind.
//  la_data_out: fields of absent channels = 0; [96+c] = TC of channel c for c < min(NUM_CH,32).
//  Reset mid-transaction: ack drops and the pending access is discarded.
// TESTING
//  1. Reset: hold wb_rst_i 2 cycles -> all outputs 0, io_oeb = 38'h3F, CTRL/COUNT read 0.
//  2. ch1 RELOAD=3, CTRL=0x3 (up, auto) -> COUNT 0,1,2,3,0,... repeating; TC set on the COUNT==3 cycle; irq stays 0 (IE=0).
//  3. ch2 RELOAD=5, COUNT=2, CTRL=0xC|EN (down, IE, no auto) -> 2,1,0 then EN=0; irq[0]=1 one cycle after TC; W1C STATUS -> irq 0.
//  4. LA override: la_oenb[64]=0, la_data_in=0x1234 while ch0 runs -> COUNT0=0x1234 each cycle; release -> counts from 0x1234.
//  5. Wishbone: sel=4'b0010 write 0xAABBCCDD to ch0 RELOAD=0 -> reads 0x0000CC00; unmapped offset reads 0; ack is one cycle per access.
//  6. Simultaneous: W1C STATUS in the TC cycle -> TC stays 1; reset during pending ack -> ack 0 next cycle.

Source files
------------

// File: rtl/user_proj_counter_bank.sv
// user_proj_counter_bank
// Multi-channel up/down counter/timer bank for the Caravel user area (instantiated as mprj).
// NUM_CH independent CNT_W-bit counters with optional auto-reload, controlled over a
// Wishbone slave. Channel 0 can be overridden from the logic analyser, channel IO_CH is
// mirrored on the user IOs, and enabled terminal-count flags raise irq[0].
//
// Ports
//   wb_clk_i, wb_rst_i       clock, synchronous active-high reset
//   wbs_cyc_i .. wbs_dat_i   Wishbone slave request (byte address, byte selects, write data)
//   wbs_ack_o, wbs_dat_o     Wishbone acknowledge (one cycle) and read data (valid with ack)
//   la_data_in, la_oenb      LA inputs; ~la_oenb[64] forces COUNT0 <= la_data_in[CNT_W-1:0]
//   la_data_out              {tc flags, ch2, ch1, ch0 counts}, registered
//   io_in                    unused
//   io_out, io_oeb           count of IO_CH on [37:6], [5:0] left as inputs
//   irq                      [0] = |(TC & IE), registered; [2:1] tied low
//
// Register map, channel c at BASE_ADR + c*0x10:
//   +0x0 CTRL {DOWN, IE, AUTO, EN}   +0x4 COUNT   +0x8 RELOAD   +0xC STATUS {TC}, W1C
module user_proj_counter_bank #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned CNT_W    = 32,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    parameter int unsigned IO_CH    = 0
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         wbs_cyc_i,
    input  logic         wbs_stb_i,
    input  logic         wbs_we_i,
    input  logic [3:0]   wbs_sel_i,
    input  logic [31:0]  wbs_adr_i,
    input  logic [31:0]  wbs_dat_i,
    output logic         wbs_ack_o,
    output logic [31:0]  wbs_dat_o,
    input  logic [127:0] la_data_in,
    output logic [127:0] la_data_out,
    input  logic [127:0] la_oenb,
    input  logic [37:0]  io_in,
    output logic [37:0]  io_out,
    output logic [37:0]  io_oeb,
    output logic [2:0]   irq
);

    // Channels whose count appears on la_data_out, and channels whose TC flag does.
    localparam int unsigned LA_CH = (NUM_CH < 3) ? NUM_CH : 3;
    localparam int unsigned TC_LA = (NUM_CH < 32) ? NUM_CH : 32;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_COUNT  = 2'd1;
    localparam logic [1:0] OFF_RELOAD = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    // Per-channel register state
    logic [NUM_CH-1:0] en_q, auto_q, ie_q, down_q, tc_q;
    logic [NUM_CH-1:0] en_d, auto_d, ie_d, down_d, tc_d;
    logic [CNT_W-1:0]  count_q  [NUM_CH];
    logic [CNT_W-1:0]  count_d  [NUM_CH];
    logic [CNT_W-1:0]  reload_q [NUM_CH];
    logic [CNT_W-1:0]  reload_d [NUM_CH];

    // Bus and observation output registers
    logic         ack_q;
    logic [31:0]  dat_q;
    logic [31:0]  dat_d;
    logic         irq_q;
    logic         irq_d;
    logic [127:0] la_q;
    logic [127:0] la_d;
    logic [31:0]  io_cnt_q;
    logic [31:0]  io_cnt_d;

    // Request decode
    logic        in_win;
    logic        req;
    logic        wr;
    logic [3:0]  ch;
    logic [1:0]  off;
    logic        la_ovr;
    logic [31:0] rd_data;

    // Per-channel counting terms
    logic [NUM_CH-1:0] term;
    logic [NUM_CH-1:0] step;
    logic [NUM_CH-1:0] hit;
    logic [NUM_CH-1:0] wsel;

    // Byte-lane merge of a write into the current 32-bit view of a register.
    function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                                input logic [31:0] wdat,
                                                input logic [3:0]  sel);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = sel[b] ? wdat[8*b +: 8] : cur[8*b +: 8];
        end
        return r;
    endfunction

    // Only the window's upper address bits select this slave; ack gates re-sampling,
    // so a held strobe is served every other cycle.
    assign in_win = (wbs_adr_i[31:8] == BASE_ADR[31:8]);
    assign req    = wbs_cyc_i & wbs_stb_i & ~ack_q & in_win;
    assign wr     = req & wbs_we_i;
    assign ch     = wbs_adr_i[7:4];
    assign off    = wbs_adr_i[3:2];
    assign la_ovr = ~la_oenb[64];

    // Read mux; channels at or above NUM_CH read as zero.
    always_comb begin
        rd_data = '0;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            if (ch == 4'(c)) begin
                unique case (off)
                    OFF_CTRL:   rd_data = {28'd0, down_q[c], ie_q[c], auto_q[c], en_q[c]};
                    OFF_COUNT:  rd_data = 32'(count_q[c]);
                    OFF_RELOAD: rd_data = 32'(reload_q[c]);
                    default:    rd_data = {31'd0, tc_q[c]};
                endcase
            end
        end
    end

    // Terminal detection; the LA override suppresses counting (and TC) on channel 0.
    always_comb begin
        for (int c = 0; c < int'(NUM_CH); c++) begin
            term[c] = down_q[c] ? (count_q[c] == '0) : (count_q[c] == reload_q[c]);
            step[c] = en_q[c] & ~((c == 0) & la_ovr);
            hit[c]  = step[c] & term[c];
            wsel[c] = wr & (ch == 4'(c));
        end
    end

    // Channel next state: counting, then Wishbone COUNT write, then LA override.
    always_comb begin
        en_d   = en_q;
        auto_d = auto_q;
        ie_d   = ie_q;
        down_d = down_q;
        tc_d   = tc_q;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            count_d[c]  = count_q[c];
            reload_d[c] = reload_q[c];

            if (step[c]) begin
                if (term[c]) begin
                    if (auto_q[c]) begin
                        count_d[c] = down_q[c] ? reload_q[c] : '0;
                    end else begin
                        en_d[c] = 1'b0;
                    end
                end else begin
                    count_d[c] = down_q[c] ? count_q[c] - CNT_W'(1) : count_q[c] + CNT_W'(1);
                end
            end

            if (wsel[c] && off == OFF_COUNT) begin
                count_d[c] = CNT_W'(merge_bytes(32'(count_q[c]), wbs_dat_i, wbs_sel_i));
            end
            if (c == 0 && la_ovr) begin
                count_d[c] = la_data_in[CNT_W-1:0];
            end

            if (wsel[c] && off == OFF_RELOAD) begin
                reload_d[c] = CNT_W'(merge_bytes(32'(reload_q[c]), wbs_dat_i, wbs_sel_i));
            end

            // An explicit CTRL write takes precedence over the auto-disable.
            if (wsel[c] && off == OFF_CTRL && wbs_sel_i[0]) begin
                {down_d[c], ie_d[c], auto_d[c], en_d[c]} = wbs_dat_i[3:0];
            end

            // A terminal event in the same cycle beats the write-1-to-clear.
            if (wsel[c] && off == OFF_STATUS && wbs_sel_i[0] && wbs_dat_i[0]) begin
                tc_d[c] = 1'b0;
            end
            if (hit[c]) begin
                tc_d[c] = 1'b1;
            end
        end
    end

    // Observation outputs are copies of the current registers, one cycle behind.
    always_comb begin
        la_d = '0;
        for (int c = 0; c < int'(LA_CH); c++) begin
            la_d[32*c +: 32] = 32'(count_q[c]);
        end
        for (int c = 0; c < int'(TC_LA); c++) begin
            la_d[96+c] = tc_q[c];
        end
        irq_d    = |(tc_q & ie_q);
        io_cnt_d = 32'(count_q[IO_CH]);
        dat_d    = (req && !wbs_we_i) ? rd_data : '0;
    end

    // State and output registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            en_q     <= '0;
            auto_q   <= '0;
            ie_q     <= '0;
            down_q   <= '0;
            tc_q     <= '0;
            for (int c = 0; c < int'(NUM_CH); c++) begin
                count_q[c]  <= '0;
                reload_q[c] <= '0;
            end
            ack_q    <= 1'b0;
            dat_q    <= '0;
            irq_q    <= 1'b0;
            la_q     <= '0;
            io_cnt_q <= '0;
        end else begin
            en_q     <= en_d;
            auto_q   <= auto_d;
            ie_q     <= ie_d;
            down_q   <= down_d;
            tc_q     <= tc_d;
            for (int c = 0; c < int'(NUM_CH); c++) begin
                count_q[c]  <= count_d[c];
                reload_q[c] <= reload_d[c];
            end
            ack_q    <= req;
            dat_q    <= dat_d;
            irq_q    <= irq_d;
            la_q     <= la_d;
            io_cnt_q <= io_cnt_d;
        end
    end

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign la_data_out = la_q;
    assign io_out      = {io_cnt_q, 6'd0};
    assign io_oeb      = {32'd0, 6'h3F};
    assign irq         = {2'b00, irq_q};

    // Inputs with no function in this design
    logic unused;
    assign unused = ^{io_in, la_data_in[127:CNT_W], la_oenb[127:65], la_oenb[63:0],
                      wbs_adr_i[1:0]};

endmodule

// File: tb/tb_user_proj_counter_bank.sv
// Testbench for user_proj_counter_bank (NUM_CH=4, CNT_W=32, IO_CH=0).
// A behavioural model advances on every rising edge from the sampled inputs and a
// compare process checks every DUT output against it on each falling edge. Directed
// sequences pin the model with hand-computed values, then random traffic follows.
module tb_user_proj_counter_bank;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cyc = 1'b0;
    logic         stb = 1'b0;
    logic         we  = 1'b0;
    logic [3:0]   sel = 4'h0;
    logic [31:0]  adr = 32'h0;
    logic [31:0]  dat = 32'h0;
    logic [127:0] la_in   = '0;
    logic [127:0] la_oenb = '1;
    logic [37:0]  io_in   = '0;

    logic         ack;
    logic [31:0]  rdat;
    logic [127:0] la_out;
    logic [37:0]  io_out;
    logic [37:0]  io_oeb;
    logic [2:0]   irq;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    user_proj_counter_bank dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbs_cyc_i   (cyc),
        .wbs_stb_i   (stb),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (dat),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (rdat),
        .la_data_in  (la_in),
        .la_data_out (la_out),
        .la_oenb     (la_oenb),
        .io_in       (io_in),
        .io_out      (io_out),
        .io_oeb      (io_oeb),
        .irq         (irq)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0]  m_cnt [4];
    logic [31:0]  m_rel [4];
    logic [3:0]   m_en, m_auto, m_ie, m_down, m_tc;
    logic         m_ack;
    logic [31:0]  m_dat;
    logic         m_irq;
    logic [127:0] m_la;
    logic [37:0]  m_io;

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] d,
                                           input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (o & ~m) | (d & m);
    endfunction

    task automatic model_tick();
        logic        req;
        logic [31:0] rd;
        int          cs;
        int          os;
        if (rst) begin
            for (int c = 0; c < 4; c++) begin
                m_cnt[c] = 0;
                m_rel[c] = 0;
            end
            {m_en, m_auto, m_ie, m_down, m_tc} = '0;
            m_ack = 0; m_dat = 0; m_irq = 0; m_la = 0; m_io = 0;
            return;
        end
        // registered views of the state as it stood before this edge
        m_irq = |(m_tc & m_ie);
        m_la  = '0;
        for (int c = 0; c < 3; c++) m_la[32*c +: 32] = m_cnt[c];
        for (int c = 0; c < 4; c++) m_la[96+c] = m_tc[c];
        m_io  = {m_cnt[0], 6'd0};

        req = cyc && stb && !m_ack && (adr[31:8] == 24'h300000);
        cs  = int'(adr[7:4]);
        os  = int'(adr[3:2]);
        rd  = 0;
        if (cs < 4) begin
            case (os)
                0:       rd = {28'd0, m_down[cs], m_ie[cs], m_auto[cs], m_en[cs]};
                1:       rd = m_cnt[cs];
                2:       rd = m_rel[cs];
                default: rd = {31'd0, m_tc[cs]};
            endcase
        end

        for (int c = 0; c < 4; c++) begin
            logic [31:0] ncnt;
            logic        nen;
            logic        ntc;
            logic        over;
            logic        hitc;
            logic        w;
            ncnt = m_cnt[c];
            nen  = m_en[c];
            ntc  = m_tc[c];
            hitc = 0;
            over = (c == 0) && !la_oenb[64];
            if (m_en[c] && !over) begin
                if (!m_down[c]) begin
                    if (m_cnt[c] == m_rel[c]) begin
                        hitc = 1;
                        if (m_auto[c]) ncnt = 0; else nen = 0;
                    end else ncnt = m_cnt[c] + 1;
                end else begin
                    if (m_cnt[c] == 0) begin
                        hitc = 1;
                        if (m_auto[c]) ncnt = m_rel[c]; else nen = 0;
                    end else ncnt = m_cnt[c] - 1;
                end
            end
            w = req && we && (cs == c);
            if (w && os == 1) ncnt = bmerge(m_cnt[c], dat, sel);
            if (over) ncnt = la_in[31:0];
            if (w && os == 2) m_rel[c] = bmerge(m_rel[c], dat, sel);
            if (w && os == 0 && sel[0]) begin
                nen       = dat[0];
                m_auto[c] = dat[1];
                m_ie[c]   = dat[2];
                m_down[c] = dat[3];
            end
            if (w && os == 3 && sel[0] && dat[0]) ntc = 0;
            if (hitc) ntc = 1;
            m_cnt[c] = ncnt;
            m_en[c]  = nen;
            m_tc[c]  = ntc;
        end
        m_ack = req;
        m_dat = (req && !we) ? rd : 32'd0;
    endtask

    always @(posedge clk) model_tick();

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            chk("ack",    ack,    m_ack);
            chk("rdata",  rdat,   m_dat);
            chk("irq",    irq,    {2'b00, m_irq});
            chk("la_out", la_out, m_la);
            chk("io_out", io_out, m_io);
            chk("io_oeb", io_oeb, 38'h3F);
        end
    end

    // ---------------- Wishbone helpers ----------------
    function automatic logic [31:0] A(input int c, input int o);
        return 32'h3000_0000 + 32'(c * 16 + o * 4);
    endfunction

    task automatic wb_acc(input logic w_we, input logic [31:0] w_adr, input logic [31:0] w_dat,
                          input logic [3:0] w_sel, output logic [31:0] r);
        int n;
        @(negedge clk);
        cyc = 1; stb = 1; we = w_we; adr = w_adr; dat = w_dat; sel = w_sel;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 8);
        if (!ack) timeout("wb_ack");
        r = rdat;
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
        logic [31:0] r;
        wb_acc(1'b1, a, d, s, r);
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] r);
        wb_acc(1'b0, a, 32'h0, 4'hF, r);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] r;
        int          n;
        logic        prev_irq;
        logic [5:0]  pat;
        int unsigned seq [4];
        seq = '{2, 3, 0, 1};

        #6 chk_on = 1'b1;

        // Reset held for two cycles
        repeat (2) @(negedge clk);
        chk("rst_ack",    ack,    0);
        chk("rst_irq",    irq,    0);
        chk("rst_la",     la_out, 0);
        chk("rst_io_out", io_out, 0);
        chk("rst_io_oeb", io_oeb, 38'h3F);
        rst = 0;
        wb_read(A(0, 0), r); chk("rst_ctrl0",  r, 0);
        wb_read(A(0, 1), r); chk("rst_count0", r, 0);

        // ch1 up with auto-reload at 3
        wb_write(A(1, 2), 32'd3);
        wb_write(A(1, 0), 32'h3);
        n = 0;
        while (la_out[63:32] != 32'd1 && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) timeout("ch1_reach_1");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("ch1_seq", la_out[63:32], seq[k]);
        end
        chk("ch1_no_irq", irq, 0);
        wb_read(A(1, 3), r); chk("ch1_tc", r, 1);

        // ch2 down from 2, IE, no auto
        wb_write(A(2, 2), 32'd5);
        wb_write(A(2, 1), 32'd2);
        wb_write(A(2, 0), 32'hD);
        n = 0;
        prev_irq = irq[0];
        while (!la_out[98] && n < 20) begin prev_irq = irq[0]; @(negedge clk); n++; end
        if (n >= 20) timeout("ch2_tc");
        chk("ch2_irq_with_tc", irq[0], 1);
        chk("ch2_irq_before",  prev_irq, 0);
        chk("ch2_count_zero",  la_out[95:64], 0);
        repeat (3) @(negedge clk);
        wb_read(A(2, 0), r); chk("ch2_ctrl_en_off", r, 32'hC);
        wb_read(A(2, 1), r); chk("ch2_count_hold", r, 0);
        chk("ch2_irq_held", irq[0], 1);
        wb_write(A(2, 3), 32'd1);
        @(negedge clk);
        chk("ch2_irq_cleared", irq[0], 0);

        // LA override of ch0 while running down
        la_in = 128'h1234;
        la_oenb[64] = 1'b0;
        wb_write(A(0, 0), 32'h9);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("la_ovr_hold", la_out[31:0], 32'h1234);
        end
        chk("la_ovr_io", io_out[37:6], 32'h1234);
        la_oenb[64] = 1'b1;
        @(negedge clk); chk("la_rel_0", la_out[31:0], 32'h1234);
        @(negedge clk); chk("la_rel_1", la_out[31:0], 32'h1233);
        @(negedge clk); chk("la_rel_2", la_out[31:0], 32'h1232);
        wb_write(A(0, 0), 32'h0);

        // Byte selects, unmapped reads, ack cadence, out-of-window
        wb_write(A(0, 2), 32'hAABBCCDD, 4'b0010);
        wb_read(A(0, 2), r); chk("sel_reload", r, 32'h0000CC00);
        wb_read(A(5, 1), r); chk("unmapped_ch5", r, 0);
        wb_read(A(9, 0), r); chk("unmapped_ch9", r, 0);
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; adr = A(0, 2); sel = 4'hF;
        pat = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            pat = {pat[4:0], ack};
        end
        chk("ack_cadence", pat, 6'b101010);
        adr = 32'h3000_0100;
        n = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (ack) n++;
        end
        chk("out_of_window", n, 0);
        cyc = 0; stb = 0;

        // W1C in the terminal cycle: ch3 up to 1, no auto
        wb_write(A(3, 2), 32'd1);
        @(negedge clk);
        cyc = 1; stb = 1; we = 1; sel = 4'hF; adr = A(3, 0); dat = 32'h1;
        @(negedge clk);
        adr = A(3, 3); dat = 32'h1;
        @(negedge clk);
        @(negedge clk);
        chk("w1c_ack", ack, 1);
        cyc = 0; stb = 0; we = 0;
        wb_read(A(3, 3), r); chk("tc_beats_w1c", r, 1);
        wb_read(A(3, 0), r); chk("ch3_auto_disabled", r, 0);
        wb_write(A(3, 3), 32'h1);
        wb_read(A(3, 3), r); chk("ch3_w1c", r, 0);

        // Reset while an ack is pending
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; adr = A(1, 2);
        @(negedge clk);
        chk("pend_ack", ack, 1);
        rst = 1;
        @(negedge clk);
        chk("rst_drops_ack", ack, 0);
        cyc = 0; stb = 0; rst = 0;
        wb_read(A(1, 2), r); chk("rst_reload1", r, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            int rr;
            @(negedge clk);
            rst = ($urandom_range(0, 399) == 0);
            cyc = ($urandom_range(0, 9) < 6);
            stb = cyc ? ($urandom_range(0, 9) < 8) : 1'($urandom_range(0, 1));
            we  = ($urandom_range(0, 2) != 0);
            rr  = int'($urandom_range(0, 19));
            if (rr == 0)      adr = $urandom;
            else if (rr == 1) adr = 32'h3000_0100 + 32'($urandom_range(0, 255));
            else adr = {24'h300000, 4'($urandom_range(0, 5)), 2'($urandom_range(0, 3)), 2'b00};
            sel = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom);
            dat = ($urandom_range(0, 3) != 0) ? 32'($urandom_range(0, 9)) : $urandom;
            la_oenb[64] = ($urandom_range(0, 9) != 0);
            la_in = {$urandom, $urandom, $urandom, 32'($urandom_range(0, 9))};
        end
        @(negedge clk);
        rst = 0; cyc = 0; stb = 0; we = 0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
